// File: rtl/l1_cache_pkg.sv
// Line, address-field and FSM state types for the direct-mapped L1 cache.
package cache_types;
  localparam int DEF_SETS = 8;
  localparam int DEF_IW   = $clog2(DEF_SETS);
  localparam int DEF_TW   = 12 - DEF_IW;

  typedef logic [127:0]       lc3b_line;
  typedef logic [DEF_TW-1:0]  cache_tag;
  typedef logic [DEF_IW-1:0]  cache_index;
  typedef logic [3:0]         cache_offset;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} cache_state_e;
endpackage

// File: rtl/lc3b_types.sv
// Core-side word and write-mask types shared by the LC-3b pipeline and its memory blocks.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
endpackage

// File: rtl/l1_cache_control.sv
// Miss-handling FSM: zero-wait hits in IDLE, optional victim writeback, then line fill.
module l1_cache_control
  import cache_types::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic wr,
  input  logic hit,
  input  logic dirty,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic load_word,
  output logic load_line,
  output logic pmem_read,
  output logic pmem_write,
  output logic sel_victim
);
  cache_state_e state, state_nxt;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;

  // A request dropped during writeback skips the fill and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (req && !hit) state_nxt = dirty ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: if (pmem_resp)   state_nxt = req ? S_ALLOCATE : S_IDLE;
      S_ALLOCATE:  if (pmem_resp)   state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_resp   = 1'b0;
    load_word  = 1'b0;
    load_line  = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    sel_victim = 1'b0;
    case (state)
      S_IDLE: begin
        mem_resp  = req && hit;
        load_word = req && hit && wr;
      end
      S_WRITEBACK: begin
        pmem_write = 1'b1;
        sel_victim = 1'b1;
      end
      S_ALLOCATE: begin
        pmem_read = 1'b1;
        load_line = pmem_resp;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/l1_cache_datapath.sv
// Tag/data/valid/dirty arrays, tag compare, byte-merge of write hits and pmem address muxing.
module l1_cache_datapath
  import lc3b_types::*;
  import cache_types::*;
#(
  parameter int NUM_SETS = DEF_SETS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_line      pmem_rdata,
  input  logic          load_word,
  input  logic          load_line,
  input  logic          pmem_active,
  input  logic          sel_victim,
  output logic          hit,
  output logic          dirty,
  output lc3b_word      mem_rdata,
  output lc3b_word      pmem_address,
  output lc3b_line      pmem_wdata
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;

  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TW-1:0]       tag_q  [NUM_SETS];
  lc3b_line            data_q [NUM_SETS];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [6:0]    wbit;
  lc3b_line      line;
  lc3b_word      cur_word, new_word;
  logic          unused_addr0;

  assign idx          = mem_address[3+IW:4];
  assign tag          = mem_address[15:4+IW];
  assign wbit         = {mem_address[3:1], 4'b0};
  assign unused_addr0 = mem_address[0];

  assign line  = data_q[idx];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign dirty = valid_q[idx] && dirty_q[idx];

  always_comb begin
    cur_word = line[wbit +: 16];
    new_word = cur_word;
    if (mem_byte_enable[0]) new_word[7:0]  = mem_wdata[7:0];
    if (mem_byte_enable[1]) new_word[15:8] = mem_wdata[15:8];
  end

  // Arrays are not reset, so gate rdata to keep it at zero while reset is held.
  assign mem_rdata    = reset_n ? cur_word : '0;
  assign pmem_wdata   = line;
  assign pmem_address = !pmem_active ? '0 :
                        sel_victim   ? {tag_q[idx], idx, 4'b0} : {tag, idx, 4'b0};

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_line) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (load_word) begin
      dirty_q[idx] <= 1'b1;
    end

  always_ff @(posedge clk)
    if (load_line) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= pmem_rdata;
    end else if (load_word) begin
      data_q[idx][wbit +: 16] <= new_word;
    end
endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back, write-allocate L1 between the LC-3b core and physical memory.
module l1_cache
  import lc3b_types::*;
  import cache_types::*;
#(
  parameter int NUM_SETS = DEF_SETS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_line      pmem_wdata,
  input  lc3b_line      pmem_rdata,
  input  logic          pmem_resp
);
  logic hit, dirty, load_word, load_line, sel_victim;

  l1_cache_control u_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (mem_read | mem_write),
    .wr         (mem_write),
    .hit        (hit),
    .dirty      (dirty),
    .pmem_resp  (pmem_resp),
    .mem_resp   (mem_resp),
    .load_word  (load_word),
    .load_line  (load_line),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .sel_victim (sel_victim)
  );

  l1_cache_datapath #(.NUM_SETS(NUM_SETS)) u_dp (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .pmem_rdata      (pmem_rdata),
    .load_word       (load_word),
    .load_line       (load_line),
    .pmem_active     (pmem_read | pmem_write),
    .sel_victim      (sel_victim),
    .hit             (hit),
    .dirty           (dirty),
    .mem_rdata       (mem_rdata),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata)
  );
endmodule
